// File: rtl/bnn_pkg.sv
// bnn_pkg: shared FSM state codes, width helpers and ROM word field offsets for the BNN sample sequencer
package bnn_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam int FEAT_LSB = 0;
  function automatic int bits_for(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic int label_lsb(input int feat_bits, input int feat_cnt);
    return feat_bits * feat_cnt;
  endfunction
endpackage

// File: rtl/bnn_latency_timer.sv
// bnn_latency_timer: load sets count to LAT; while en counts down, expire pulses on the (LAT+1)th enabled cycle
module bnn_latency_timer
  import bnn_pkg::*;
#(
  parameter int LAT = 46
)(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = bits_for(LAT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(LAT);
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end
  assign expire = en && cnt == '0;
endmodule

// File: rtl/bnn_sample_sequencer.sv
// bnn_sample_sequencer: fetches {label,features} from ROM, drives the classifier, emits per-sample results on res_valid/res_ready and keeps correct_cnt
module bnn_sample_sequencer
  import bnn_pkg::*;
#(
  parameter int FEAT_CNT   = 11,
  parameter int FEAT_BITS  = 4,
  parameter int HIDDEN_CNT = 40,
  parameter int CLASS_CNT  = 6,
  parameter int TEST_CNT   = 1000,
  localparam int LAT      = HIDDEN_CNT + CLASS_CNT,
  localparam int CLS_BITS = bits_for(CLASS_CNT),
  localparam int IDX_BITS = bits_for(TEST_CNT),
  localparam int CNT_BITS = bits_for(TEST_CNT + 1),
  localparam int FEAT_W   = FEAT_BITS * FEAT_CNT
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [IDX_BITS-1:0]  rom_addr,
  input  logic [CLS_BITS+FEAT_W-1:0] rom_data,
  output logic [FEAT_W-1:0]    clf_features,
  output logic                 clf_rst,
  input  logic [CLS_BITS-1:0]  clf_prediction,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDX_BITS-1:0]  res_index,
  output logic [CLS_BITS-1:0]  res_pred,
  output logic                 res_correct,
  output logic [CNT_BITS-1:0]  correct_cnt,
  output logic                 busy,
  output logic                 done
);
  localparam int LABEL_LSB = label_lsb(FEAT_BITS, FEAT_CNT);
  logic [2:0] state;
  logic [IDX_BITS-1:0] idx;
  logic [CLS_BITS-1:0] label;
  logic expire;
  bnn_latency_timer #(.LAT(LAT)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(state == S_LOAD),
    .en(state == S_RUN),
    .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      label        <= '0;
      clf_features <= '0;
      res_pred     <= '0;
      res_correct  <= 1'b0;
      correct_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          idx         <= '0;
          correct_cnt <= '0;
          state       <= S_FETCH;
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          clf_features <= rom_data[FEAT_LSB +: FEAT_W];
          label        <= rom_data[LABEL_LSB +: CLS_BITS];
          state        <= S_RUN;
        end
        S_RUN: if (expire) begin
          res_pred    <= clf_prediction;
          res_correct <= clf_prediction == label;
          state       <= S_EMIT;
        end
        S_EMIT: if (res_ready) begin
          correct_cnt <= correct_cnt + CNT_BITS'(res_correct);
          state       <= idx == IDX_BITS'(TEST_CNT - 1) ? S_DONE : S_FETCH;
          if (idx != IDX_BITS'(TEST_CNT - 1)) idx <= idx + IDX_BITS'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign rom_addr  = idx;
  assign res_index = idx;
  assign clf_rst   = !(state == S_RUN || state == S_EMIT);
  assign res_valid = state == S_EMIT;
  assign busy      = state == S_FETCH || state == S_LOAD || state == S_RUN || state == S_EMIT;
  assign done      = state == S_DONE;
endmodule

// File: tb/tb_bnn_sample_sequencer.sv
// tb_bnn_sample_sequencer: table-driven and directed checks of bnn_sample_sequencer with a ROM and a latency-accurate classifier model
module tb_bnn_sample_sequencer;
  localparam int FC = 11, FB = 4, HC = 3, CC = 4, TC = 4;
  localparam int LAT = HC + CC;
  localparam logic [39:0] FEAT_REST = 40'hA5C396E17B;
  logic clk = 0, rst = 1, start = 0, res_ready = 1;
  logic [1:0] rom_addr, clf_prediction, res_index, res_pred;
  logic [45:0] rom_data = '0;
  logic [43:0] clf_features;
  logic clf_rst, res_valid, res_correct, busy, done;
  logic [2:0] correct_cnt;
  logic [45:0] rom [4];
  logic [7:0] mcnt = '0;
  int applied = 0, miscompares = 0;
  typedef struct {
    logic [3:0] f0;
    logic [1:0] label;
    logic [1:0] exp_pred;
    logic       exp_correct;
  } vec_t;
  vec_t vecs [8];

  bnn_sample_sequencer #(.FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC), .TEST_CNT(TC)) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .clf_features(clf_features), .clf_rst(clf_rst), .clf_prediction(clf_prediction),
    .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index), .res_pred(res_pred),
    .res_correct(res_correct), .correct_cnt(correct_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  // classifier answer is only right once LAT cycles have elapsed since clf_rst released
  always @(posedge clk) mcnt <= clf_rst ? 8'd0 : (mcnt == 8'hff ? mcnt : mcnt + 8'd1);
  assign clf_prediction = (mcnt >= 8'(LAT)) ? clf_features[1:0] : clf_features[1:0] + 2'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_features"}, clf_features, 0);
    chk({tag, "_clf_rst"}, clf_rst, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_index"}, res_index, 0);
    chk({tag, "_res_pred"}, res_pred, 0);
    chk({tag, "_res_correct"}, res_correct, 0);
    chk({tag, "_correct_cnt"}, correct_cnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic load_rom(input int base);
    for (int i = 0; i < 4; i++) rom[i] = {vecs[base+i].label, FEAT_REST, vecs[base+i].f0};
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_reached"}, done, 1);
  endtask

  task automatic run_table(input int base);
    int n, got, lowrun, exp_cnt;
    logic [43:0] pf;
    logic pr;
    load_rom(base);
    exp_cnt = 0;
    got = 0;
    lowrun = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    n = 1;
    pf = clf_features;
    pr = clf_rst;
    while (!done && n < 300) begin
      start = (n == 20);
      @(negedge clk);
      n++;
      if (clf_features !== pf) chk("feat_change_only_after_load", {pr, clf_rst}, 2'b10);
      pf = clf_features;
      pr = clf_rst;
      lowrun = clf_rst ? 0 : (res_valid ? lowrun : lowrun + 1);
      if (res_valid && got < 4) begin
        chk("res_index", res_index, got);
        chk("res_pred", res_pred, vecs[base+got].exp_pred);
        chk("res_correct", res_correct, vecs[base+got].exp_correct);
        chk("clf_rst_low_before_capture", lowrun, LAT + 1);
        exp_cnt += int'(vecs[base+got].exp_correct);
        got++;
      end
    end
    start = 0;
    chk("results_seen", got, 4);
    chk("done_cycle", n, TC * (LAT + 4) + 1);
    chk("final_correct_cnt", correct_cnt, exp_cnt);
    repeat (5) @(negedge clk);
    chk("done_held", {done, busy}, 2'b10);
  endtask

  initial begin
    vecs[0] = '{4'd5,  2'd1, 2'd1, 1'b1};
    vecs[1] = '{4'd2,  2'd2, 2'd2, 1'b1};
    vecs[2] = '{4'd7,  2'd3, 2'd3, 1'b1};
    vecs[3] = '{4'd12, 2'd0, 2'd0, 1'b1};
    vecs[4] = '{4'd9,  2'd1, 2'd1, 1'b1};
    vecs[5] = '{4'd14, 2'd0, 2'd2, 1'b0};
    vecs[6] = '{4'd3,  2'd3, 2'd3, 1'b1};
    vecs[7] = '{4'd8,  2'd1, 2'd0, 1'b0};
    load_rom(0);
    repeat (3) @(negedge clk);
    rst = 0;
    check_rst("reset");

    run_table(0);
    run_table(4);

    begin : backpressure
      int n = 0;
      load_rom(0);
      res_ready = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      while (!res_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("bp_valid_reached", res_valid, 1);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk("bp_stable", {res_valid, res_index, res_pred, clf_rst, correct_cnt}, {1'b1, 2'd0, 2'd1, 1'b0, 3'd0});
      end
      res_ready = 1;
      @(negedge clk);
      chk("bp_after_handshake", {res_valid, correct_cnt}, {1'b0, 3'd1});
      wait_done("bp");
      chk("bp_final_cnt", correct_cnt, 4);
    end

    begin : rst_in_run
      int n = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      while (!(res_index == 2 && !clf_rst && !res_valid) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("run2_reached", {res_index, clf_rst, res_valid}, {2'd2, 1'b0, 1'b0});
      rst = 1;
      @(negedge clk);
      rst = 0;
      check_rst("midrun_rst");
      start = 1;
      @(negedge clk);
      start = 0;
      n = 0;
      while (!res_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("restart_first_index", {res_valid, res_index, correct_cnt}, {1'b1, 2'd0, 3'd0});
      wait_done("restart");
      chk("restart_final_cnt", correct_cnt, 4);
    end

    start = 1;
    rst = 1;
    @(negedge clk);
    start = 0;
    rst = 0;
    check_rst("start_rst");
    repeat (3) @(negedge clk);
    chk("start_rst_stays_idle", {busy, done, clf_rst}, 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
